// File: rtl/any1_tlb_nway.sv
// N-way set-associative data TLB for ANY-1: ASID-qualified lookup with A/D update in hardware,
// round-robin auto-replacement, and full or per-ASID flush walked one set per cycle.
module any1_tlb_nway #(
   parameter int          AWID     = 32,
   parameter int          WAYS     = 4,
   parameter int          SETS_LG2 = 6,
   parameter int          PG_LG2   = 14,
   parameter int          ASIDW    = 8,
   parameter logic [63:0] RSTIP    = 64'hFFFFFFFFFFFD0000
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [ASIDW-1:0]    asid_i,
   input  logic                umode_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [AWID-1:0]     ladr_i,
   output logic                rdy_o,
   output logic [AWID-1:0]     padr_o,
   output logic [3:0]          acr_o,
   output logic                miss_o,
   output logic                busy_o,
   input  logic                tlbwr_i,
   input  logic                tlbauto_i,
   input  logic                tlbrd_i,
   input  logic [SETS_LG2+2:0] tlbadr_i,
   input  logic [63:0]         tlbdat_i,
   output logic [63:0]         tlbdat_o,
   input  logic                flush_i,
   input  logic                flasid_i,
   output logic [1:0]          dbg_state
);

   localparam int SETS = 1 << SETS_LG2;
   localparam int TAGW = AWID - PG_LG2 - SETS_LG2;
   localparam int PPNW = AWID - PG_LG2;

   typedef enum logic [1:0] {IDLE = 2'd0, UPD = 2'd1, FLUSH = 2'd2, MAINT = 2'd3} state_t;
   state_t state, state_nxt;

   // Entry payload has no reset; only the valid bits are cleared by reset and flush.
   logic [63:0]     ent [WAYS][SETS];
   logic [SETS-1:0] vld [WAYS];

   logic [SETS_LG2-1:0] lk_set;
   logic [TAGW-1:0]     lk_tag;
   logic                bypass;
   logic                hit, hit_a, hit_d;
   logic [2:0]          hit_way;
   logic [3:0]          hit_acr;
   logic [PPNW-1:0]     hit_ppn;

   logic                flush_any, flush_go, maint_go, accept, need_upd;
   logic [SETS_LG2-1:0] mt_set;
   logic [2:0]          mt_way, wr_way, rr;
   logic [63:0]         rd_ent;
   logic                rd_v;

   logic [SETS_LG2-1:0] fl_set;
   logic                fl_asid_only;
   logic [ASIDW-1:0]    fl_asid;
   logic [2:0]          upd_way;
   logic [SETS_LG2-1:0] upd_set;
   logic                upd_we;

   assign lk_set = ladr_i[PG_LG2 +: SETS_LG2];
   assign lk_tag = ladr_i[AWID-1 -: TAGW];
   assign bypass = !umode_i || (&ladr_i[AWID-1:24]);

   // Lowest-numbered hitting way wins.
   always_comb begin
      hit     = 1'b0;
      hit_a   = 1'b0;
      hit_d   = 1'b0;
      hit_way = '0;
      hit_acr = '0;
      hit_ppn = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && vld[w][lk_set] && (ent[w][lk_set][32 +: TAGW] == lk_tag) &&
             (ent[w][lk_set][55] || (ent[w][lk_set][56 +: ASIDW] == asid_i))) begin
            hit     = 1'b1;
            hit_way = 3'(w);
            hit_acr = ent[w][lk_set][51:48];
            hit_ppn = ent[w][lk_set][PPNW-1:0];
            hit_a   = ent[w][lk_set][53];
            hit_d   = ent[w][lk_set][54];
         end
      end
   end

   // Lookups are only taken in IDLE with no flush/maintenance request on the same edge.
   assign flush_any = flush_i || flasid_i;
   assign flush_go  = flush_any && (state != FLUSH);
   assign maint_go  = (tlbwr_i || tlbrd_i) && (state != FLUSH) && !flush_any;
   assign accept    = req_i && (state == IDLE) && !flush_any && !tlbwr_i && !tlbrd_i;
   assign need_upd  = accept && !bypass && hit && (!hit_a || (we_i && !hit_d));

   assign mt_set = tlbadr_i[SETS_LG2-1:0];
   assign mt_way = tlbadr_i[SETS_LG2 +: 3];
   assign wr_way = tlbauto_i ? rr : mt_way;

   always_comb begin
      rd_ent = '0;
      rd_v   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (mt_way == 3'(w)) begin
            rd_ent = ent[w][mt_set];
            rd_v   = vld[w][mt_set];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (flush_go)      state_nxt = FLUSH;
            else if (maint_go) state_nxt = MAINT;
            else if (need_upd) state_nxt = UPD;
         end
         UPD, MAINT: begin
            if (flush_go)      state_nxt = FLUSH;
            else if (maint_go) state_nxt = MAINT;
            else               state_nxt = IDLE;
         end
         FLUSH: begin
            if (!flush_i && (&fl_set)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_o    = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_o        <= 1'b0;
         padr_o       <= RSTIP[AWID-1:0];
         acr_o        <= '0;
         miss_o       <= 1'b0;
         tlbdat_o     <= '0;
         rr           <= '0;
         fl_set       <= '0;
         fl_asid_only <= 1'b0;
         fl_asid      <= '0;
         upd_way      <= '0;
         upd_set      <= '0;
         upd_we       <= 1'b0;
         for (int w = 0; w < WAYS; w++) vld[w] <= '0;
      end else begin
         rdy_o <= accept;
         if (accept) begin
            if (bypass) begin
               padr_o <= ladr_i;
               acr_o  <= 4'hF;
               miss_o <= 1'b0;
            end else if (hit) begin
               padr_o <= {hit_ppn, ladr_i[PG_LG2-1:0]};
               acr_o  <= hit_acr;
               miss_o <= 1'b0;
            end else begin
               miss_o <= 1'b1;
            end
         end
         if (need_upd) begin
            upd_way <= hit_way;
            upd_set <= lk_set;
            upd_we  <= we_i;
         end

         if (flush_go) begin
            fl_set       <= '0;
            fl_asid_only <= !flush_i;
            fl_asid      <= asid_i;
         end else if (state == FLUSH) begin
            // A full flush arriving mid-walk restarts from set 0 and drops any ASID qualifier.
            if (flush_i) begin
               fl_set       <= '0;
               fl_asid_only <= 1'b0;
            end else begin
               fl_set <= fl_set + 1'b1;
            end
            for (int w = 0; w < WAYS; w++) begin
               if (!fl_asid_only ||
                   (!ent[w][fl_set][55] && (ent[w][fl_set][56 +: ASIDW] == fl_asid)))
                  vld[w][fl_set] <= 1'b0;
            end
         end

         if (maint_go && tlbwr_i) begin
            for (int w = 0; w < WAYS; w++) begin
               if (wr_way == 3'(w)) vld[w][mt_set] <= tlbdat_i[52];
            end
            if (tlbauto_i) rr <= (rr == 3'(WAYS-1)) ? 3'd0 : rr + 3'd1;
         end
         if (maint_go && tlbrd_i) tlbdat_o <= {rd_ent[63:53], rd_v, rd_ent[51:0]};
      end
   end

   always_ff @(posedge clk_i) begin
      for (int w = 0; w < WAYS; w++) begin
         if ((state == UPD) && (upd_way == 3'(w))) begin
            ent[w][upd_set][53] <= 1'b1;
            ent[w][upd_set][54] <= ent[w][upd_set][54] | upd_we;
         end
         if (maint_go && tlbwr_i && (wr_way == 3'(w))) ent[w][mt_set] <= tlbdat_i;
      end
   end

endmodule

// File: tb/tb_any1_tlb_nway.sv
// Bench for any1_tlb_nway: lookups push expected {miss,acr,padr} to a queue that a negedge
// monitor pops on every rdy_o pulse; maintenance, A/D update and flush checked inline.
module tb_any1_tlb_nway;

   localparam int K_MISS = 0;
   localparam int K_HIT  = 1;
   localparam int K_BYP  = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [7:0]  asid_i = '0;
   logic        umode_i = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] ladr_i = '0;
   logic        rdy_o;
   logic [31:0] padr_o;
   logic [3:0]  acr_o;
   logic        miss_o;
   logic        busy_o;
   logic        tlbwr_i = 1'b0;
   logic        tlbauto_i = 1'b0;
   logic        tlbrd_i = 1'b0;
   logic [8:0]  tlbadr_i = '0;
   logic [63:0] tlbdat_i = '0;
   logic [63:0] tlbdat_o;
   logic        flush_i = 1'b0;
   logic        flasid_i = 1'b0;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [36:0] exp_q[$];
   logic [36:0] mon_exp;
   logic [31:0] model_padr = 32'hFFFD0000;
   logic [3:0]  model_acr = 4'h0;
   int          nbusy;

   any1_tlb_nway dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .asid_i(asid_i), .umode_i(umode_i),
      .req_i(req_i), .we_i(we_i), .ladr_i(ladr_i), .rdy_o(rdy_o), .padr_o(padr_o),
      .acr_o(acr_o), .miss_o(miss_o), .busy_o(busy_o), .tlbwr_i(tlbwr_i),
      .tlbauto_i(tlbauto_i), .tlbrd_i(tlbrd_i), .tlbadr_i(tlbadr_i), .tlbdat_i(tlbdat_i),
      .tlbdat_o(tlbdat_o), .flush_i(flush_i), .flasid_i(flasid_i), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk_ent(input logic [7:0] asid, input logic g, input logic d,
                                          input logic a, input logic [3:0] acr,
                                          input logic [15:0] tag, input logic [31:0] ppn);
      return {asid, g, d, a, 1'b1, acr, tag, ppn};
   endfunction

   function automatic logic [31:0] va(input logic [11:0] tag, input logic [5:0] set,
                                      input logic [13:0] off);
      return {tag, set, off};
   endfunction

   // scoreboard monitor
   always @(negedge clk_i) begin
      if (rdy_o) begin
         if (exp_q.size() == 0) begin
            check("rdy_unexpected", 64'(rdy_o), 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("lookup", {27'd0, miss_o, acr_o, padr_o}, {27'd0, mon_exp});
         end
      end
   end

   // driver tasks
   task automatic lookup(input logic [7:0] asid, input logic [31:0] ladr, input logic we,
                         input logic um, input int kind, input logic [3:0] acr,
                         input logic [31:0] ppn);
      bit done = 0;
      if (kind == K_HIT) begin
         model_padr = {ppn[17:0], ladr[13:0]};
         model_acr  = acr;
      end else if (kind == K_BYP) begin
         model_padr = ladr;
         model_acr  = 4'hF;
      end
      exp_q.push_back({(kind == K_MISS), model_acr, model_padr});
      asid_i = asid; ladr_i = ladr; we_i = we; umode_i = um; req_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (!busy_o) begin
            @(posedge clk_i); #1;
            done = 1;
            break;
         end
         @(posedge clk_i); #1;
      end
      req_i = 1'b0; we_i = 1'b0;
      if (!done) begin
         check("lookup_accept", 64'd0, 64'd1);
         void'(exp_q.pop_back());
      end
   endtask

   task automatic tlb_write(input logic auto_way, input logic [2:0] way, input logic [5:0] set,
                            input logic [63:0] dat);
      tlbwr_i = 1'b1; tlbauto_i = auto_way; tlbadr_i = {way, set}; tlbdat_i = dat;
      @(posedge clk_i); #1;
      tlbwr_i = 1'b0; tlbauto_i = 1'b0;
   endtask

   task automatic tlb_read(input string tag, input logic [2:0] way, input logic [5:0] set,
                           input logic [63:0] exp);
      tlbrd_i = 1'b1; tlbadr_i = {way, set};
      @(posedge clk_i); #1;
      tlbrd_i = 1'b0;
      @(negedge clk_i);
      check(tag, tlbdat_o, exp);
   endtask

   task automatic measure_busy(input int restart_at, output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (flush_i) flush_i = 1'b0;
         if (!busy_o) break;
         n++;
         if (n == restart_at) flush_i = 1'b1;
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_padr", 64'(padr_o), 64'h0000_0000_FFFD_0000);
      check("rst_rdy", 64'(rdy_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_miss_acr", {59'd0, miss_o, acr_o}, 64'd0);
      check("rst_tlbdat", tlbdat_o, 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      lookup(8'd3, va(12'h012, 6'd5, 14'h0123), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);

      // basic hit: way2/set5, ASID 3, tag 0x012, PPN 0xABC
      tlb_write(1'b0, 3'd2, 6'd5, mk_ent(8'd3, 1'b0, 1'b1, 1'b1, 4'hD, 16'h0012, 32'hABC));
      @(negedge clk_i);
      check("maint_busy", 64'(busy_o), 64'd1);
      check("maint_state", 64'(dbg_state), 64'd3);
      lookup(8'd3, va(12'h012, 6'd5, 14'h0123), 1'b0, 1'b1, K_HIT, 4'hD, 32'hABC);
      check("hit_padr_abs", 64'(model_padr), 64'h0000_0000_02AF_0123);
      @(negedge clk_i);
      check("no_upd_busy", 64'(busy_o), 64'd0);

      // store to an entry with A=0,D=0 -> one update cycle, then A=D=1
      tlb_write(1'b0, 3'd2, 6'd5, mk_ent(8'd3, 1'b0, 1'b0, 1'b0, 4'hD, 16'h0012, 32'hABC));
      lookup(8'd3, va(12'h012, 6'd5, 14'h0456), 1'b1, 1'b1, K_HIT, 4'hD, 32'hABC);
      @(negedge clk_i);
      check("upd_busy", 64'(busy_o), 64'd1);
      check("upd_state", 64'(dbg_state), 64'd1);
      @(negedge clk_i);
      check("upd_done", 64'(busy_o), 64'd0);
      tlb_read("rd_ad", 3'd2, 6'd5, mk_ent(8'd3, 1'b0, 1'b1, 1'b1, 4'hD, 16'h0012, 32'hABC));

      // ASID mismatch misses unless global
      lookup(8'd4, va(12'h012, 6'd5, 14'h0123), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);
      tlb_write(1'b0, 3'd2, 6'd5, mk_ent(8'd3, 1'b1, 1'b1, 1'b1, 4'hD, 16'h0012, 32'hABC));
      lookup(8'd4, va(12'h012, 6'd5, 14'h0777), 1'b0, 1'b1, K_HIT, 4'hD, 32'hABC);

      // bypass: supervisor mode, and the all-ones top region in user mode
      lookup(8'd4, 32'h1234_5678, 1'b1, 1'b0, K_BYP, 4'h0, 32'h0);
      lookup(8'd4, 32'hFF00_1234, 1'b0, 1'b1, K_BYP, 4'h0, 32'h0);
      lookup(8'd9, va(12'h7A5, 6'd33, 14'h0010), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);

      // round-robin auto writes to set 0; the way field is ignored
      for (int i = 0; i < 5; i++)
         tlb_write(1'b1, 3'd7, 6'd0,
                   mk_ent(8'd3, 1'b0, 1'b1, 1'b1, 4'h8, 16'h0100 + 16'(i), 32'h200 + 32'(i)));
      tlb_read("rr_way0", 3'd0, 6'd0, mk_ent(8'd3, 1'b0, 1'b1, 1'b1, 4'h8, 16'h0104, 32'h204));
      for (int i = 1; i < 4; i++)
         tlb_read("rr_way", 3'(i), 6'd0,
                  mk_ent(8'd3, 1'b0, 1'b1, 1'b1, 4'h8, 16'h0100 + 16'(i), 32'h200 + 32'(i)));
      lookup(8'd3, va(12'h100, 6'd0, 14'h0001), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);
      lookup(8'd3, va(12'h104, 6'd0, 14'h3FFF), 1'b0, 1'b1, K_HIT, 4'h8, 32'h204);
      tlb_read("rd_noway", 3'd5, 6'd0, 64'd0);

      // per-ASID flush
      tlb_write(1'b0, 3'd0, 6'd7, mk_ent(8'd3, 1'b0, 1'b1, 1'b1, 4'hC, 16'h0020, 32'h300));
      tlb_write(1'b0, 3'd1, 6'd9, mk_ent(8'd7, 1'b0, 1'b1, 1'b1, 4'hA, 16'h0030, 32'h400));
      @(posedge clk_i); #1;
      asid_i = 8'd3; flasid_i = 1'b1;
      @(posedge clk_i); #1;
      flasid_i = 1'b0;
      measure_busy(0, nbusy);
      check("flasid_cycles", 64'(nbusy), 64'd64);
      lookup(8'd3, va(12'h020, 6'd7, 14'h0002), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);
      lookup(8'd3, va(12'h104, 6'd0, 14'h0002), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);
      lookup(8'd3, va(12'h012, 6'd5, 14'h0002), 1'b0, 1'b1, K_HIT, 4'hD, 32'hABC);
      lookup(8'd7, va(12'h030, 6'd9, 14'h0040), 1'b0, 1'b1, K_HIT, 4'hA, 32'h400);

      // global flush restarted mid-walk
      @(posedge clk_i); #1;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      measure_busy(10, nbusy);
      check("flush_restart_cycles", 64'(nbusy), 64'd74);
      lookup(8'd3, va(12'h012, 6'd5, 14'h0002), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);
      lookup(8'd7, va(12'h030, 6'd9, 14'h0040), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);

      // reset in the middle of a flush
      tlb_write(1'b0, 3'd2, 6'd5, mk_ent(8'd3, 1'b1, 1'b1, 1'b1, 4'hD, 16'h0012, 32'hABC));
      lookup(8'd3, va(12'h012, 6'd5, 14'h0100), 1'b0, 1'b1, K_HIT, 4'hD, 32'hABC);
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      repeat (5) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("midflush_rst_busy", 64'(busy_o), 64'd0);
      check("midflush_rst_padr", 64'(padr_o), 64'h0000_0000_FFFD_0000);
      model_padr = 32'hFFFD0000;
      model_acr  = 4'h0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      lookup(8'd3, va(12'h012, 6'd5, 14'h0100), 1'b0, 1'b1, K_MISS, 4'h0, 32'h0);

      repeat (3) @(negedge clk_i);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
